// File: rtl/gbc_oam_dma.sv
// OAM DMA initiator: copies LENGTH bytes from a 256-byte source page into OAM over the shared block-RAM ports.
// Optional GBC_OAM_DMA_RESTART_EN: a start pulse while busy restarts the transfer instead of being ignored.
module gbc_oam_dma #(
    parameter int LENGTH          = 160,
    parameter int CYCLES_PER_BYTE = 4
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        start,
    input  logic [7:0]  src_hi,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        bus_lock,
    output logic        done
);

    localparam int             PW         = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PW-1:0]  PACE_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0]  PACE_FIRST = (CYCLES_PER_BYTE > 1) ? PW'(1) : '0;
    localparam logic [8:0]     IDX_LAST   = 9'(LENGTH - 1);
    localparam logic [7:0]     WR_LAST    = 8'(LENGTH - 1);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t         state_q;
    logic [7:0]     page_q;
    logic [8:0]     idx_q;
    logic [PW-1:0]  pace_q;
    logic           cap_q;
    logic [7:0]     capIdx_q;
    logic           rd_en_q;
    logic [15:0]    rd_addr_q;
    logic           wr_en_q;
    logic [7:0]     wr_addr_q;
    logic [7:0]     wr_data_q;
    logic           busy_q;
    logic           done_q;
    logic           launch;

    // Echo RAM pages E0-FF alias the WRAM pages 0x20 below them.
    function automatic logic [7:0] mapPage(input logic [7:0] hi);
        return (hi >= 8'hE0) ? hi - 8'h20 : hi;
    endfunction

`ifdef GBC_OAM_DMA_RESTART_EN
    assign launch = start;
`else
    assign launch = start && (state_q == IDLE);
`endif

    // Byte 0 is issued on the accepting edge itself; later bytes follow every CYCLES_PER_BYTE edges.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q   <= IDLE;
            page_q    <= '0;
            idx_q     <= '0;
            pace_q    <= '0;
            cap_q     <= 1'b0;
            capIdx_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            cap_q    <= rd_en_q;
            capIdx_q <= rd_addr_q[7:0];
            if (cap_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= capIdx_q;
                wr_data_q <= rd_data;
            end
            if (launch) begin
                page_q    <= mapPage(src_hi);
                rd_en_q   <= 1'b1;
                rd_addr_q <= {mapPage(src_hi), 8'h00};
                idx_q     <= 9'd1;
                pace_q    <= PACE_FIRST;
                busy_q    <= 1'b1;
                state_q   <= (LENGTH == 1) ? DRAIN : XFER;
                // A restart drops whatever read data is still in the pipeline.
                if (state_q != IDLE) begin
                    cap_q   <= 1'b0;
                    wr_en_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    XFER: begin
                        pace_q <= (pace_q == PACE_LAST) ? '0 : pace_q + PW'(1);
                        if (pace_q == '0) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= {page_q, idx_q[7:0]};
                            idx_q     <= idx_q + 9'd1;
                            if (idx_q == IDX_LAST) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (wr_en_q && (wr_addr_q == WR_LAST)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign bus_lock = busy_q;
    assign done     = done_q;

endmodule
